// File: rtl/hqm_aw_rtdr_pkg.sv
// Shared types and helpers for the remote TDR bank: FSM state encoding,
// counter sizing and the one-hot select check.
package hqm_aw_rtdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAP   = 2'd1,
    SHIFT = 2'd2
  } rtdr_state_t;

  // Upper bound on bank size accepted by onehot_valid.
  localparam int unsigned MAX_REG = 64;

  // The counter must reach DWIDTH+1 so that an over-length shift is distinguishable.
  function automatic int unsigned count_width(input int unsigned dwidth);
    return $clog2(dwidth + 2);
  endfunction

  function automatic logic onehot_valid(input logic [MAX_REG-1:0] vec);
    return (vec != '0) && ((vec & (vec - {{(MAX_REG-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/hqm_aw_rtdr_bank_if.sv
// TAP-side strobes and functional-side parallel buses of the remote TDR bank.
// The master drives the DR-phase strobes; the slave is the bank itself.
interface hqm_aw_rtdr_bank_if #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned NUM_REG = 4
);

  logic                              tdi;
  logic [NUM_REG-1:0]                irdec;
  logic                              capturedr;
  logic                              shiftdr;
  logic                              updatedr;
  logic                              unlock;
  logic                              err_clr;
  logic [NUM_REG-1:0][DWIDTH-1:0]    func_pi;
  logic [NUM_REG-1:0][DWIDTH-1:0]    func_po;
  logic [NUM_REG-1:0]                upd_pulse;
  logic                              len_err;
  logic                              lock_err;
  logic                              tdo;

  modport master (
    output tdi, irdec, capturedr, shiftdr, updatedr, unlock, err_clr, func_pi,
    input  func_po, upd_pulse, len_err, lock_err, tdo
  );

  modport slave (
    input  tdi, irdec, capturedr, shiftdr, updatedr, unlock, err_clr, func_pi,
    output func_po, upd_pulse, len_err, lock_err, tdo
  );

endinterface

// File: rtl/hqm_aw_rtdr_shift_chain.sv
// Shared capture/shift register of the bank with a saturating shift counter.
// Load wins over shift; the counter stops at DWIDTH+1.
module hqm_aw_rtdr_shift_chain #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CW     = 6
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              tdi_i,
  input  logic [DWIDTH-1:0] par_i,
  output logic [DWIDTH-1:0] chain_o,
  output logic [CW-1:0]     count_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DWIDTH + 1);

  logic [DWIDTH-1:0] chain_q, chain_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    chain_d = chain_q;
    count_d = count_q;
    if (load_i) begin
      chain_d = par_i;
      count_d = '0;
    end else if (shift_i) begin
      chain_d = {tdi_i, chain_q[DWIDTH-1:1]};
      if (count_q != CNT_MAX) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge tck) begin
    if (trst) begin
      chain_q <= '0;
      count_q <= '0;
    end else begin
      chain_q <= chain_d;
      count_q <= count_d;
    end
  end

  assign chain_o = chain_q;
  assign count_o = count_q;

endmodule

// File: rtl/hqm_aw_rtdr_bank.sv
// Bank of NUM_REG remote TDRs sharing one capture/shift chain, with length
// and unlock checks on update, sticky error flags and a 1-bit bypass path.
module hqm_aw_rtdr_bank
  import hqm_aw_rtdr_pkg::*;
#(
  parameter int unsigned       DWIDTH    = 32,
  parameter int unsigned       NUM_REG   = 4,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0,
  parameter bit                CHECK_LEN = 1'b1
) (
  input logic               tck,
  input logic               trst,
  hqm_aw_rtdr_bank_if.slave bus
);

  localparam int unsigned SEL_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam int unsigned CW    = count_width(DWIDTH);

  rtdr_state_t                    state_q, state_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [NUM_REG-1:0][DWIDTH-1:0] func_po_q, func_po_d;
  logic [NUM_REG-1:0]             upd_pulse_q, upd_pulse_d;
  logic                           len_err_q, len_err_d;
  logic                           lock_err_q, lock_err_d;
  logic                           byp_q, byp_d;

  logic [MAX_REG-1:0] irdec_ext;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel_idx;
  logic               same_sel;
  logic               load, shift;
  logic               commit, set_len, set_lock;
  logic [DWIDTH-1:0]  chain;
  logic [CW-1:0]      count;

  assign irdec_ext = MAX_REG'(bus.irdec);
  assign sel_valid = onehot_valid(irdec_ext);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_REG); i++) begin
      if (bus.irdec[i]) begin
        sel_idx = SEL_W'(i);
      end
    end
  end

  // The operation continues only while the decode still points at the captured register.
  assign same_sel = sel_valid && (sel_idx == sel_q);

  hqm_aw_rtdr_shift_chain #(
    .DWIDTH (DWIDTH),
    .CW     (CW)
  ) u_chain (
    .tck     (tck),
    .trst    (trst),
    .load_i  (load),
    .shift_i (shift),
    .tdi_i   (bus.tdi),
    .par_i   (bus.func_pi[sel_idx]),
    .chain_o (chain),
    .count_o (count)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    load     = 1'b0;
    shift    = 1'b0;
    commit   = 1'b0;
    set_len  = 1'b0;
    set_lock = 1'b0;
    if (bus.capturedr && sel_valid) begin
      state_d = CAP;
      sel_d   = sel_idx;
      load    = 1'b1;
    end else if (state_q != IDLE) begin
      if (!same_sel) begin
        state_d = IDLE;
      end else if (bus.shiftdr) begin
        state_d = SHIFT;
        shift   = 1'b1;
      end else if (bus.updatedr) begin
        state_d = IDLE;
        if (CHECK_LEN && (count != CW'(DWIDTH))) begin
          set_len = 1'b1;
        end else if (!bus.unlock) begin
          set_lock = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    func_po_d   = func_po_q;
    upd_pulse_d = '0;
    byp_d       = byp_q;
    if (commit) begin
      func_po_d[sel_q]   = chain;
      upd_pulse_d[sel_q] = 1'b1;
    end
    if (!sel_valid) begin
      if (bus.capturedr) begin
        byp_d = 1'b0;
      end else if (bus.shiftdr) begin
        byp_d = bus.tdi;
      end
    end
    // A new error in the same cycle as err_clr stays set.
    len_err_d  = set_len  | (len_err_q  & ~bus.err_clr);
    lock_err_d = set_lock | (lock_err_q & ~bus.err_clr);
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      // NOTE: the output slices are individual control flops, not a RAM, so they take a reset value.
      func_po_q   <= {NUM_REG{RESET_VAL}};
      upd_pulse_q <= '0;
      len_err_q   <= 1'b0;
      lock_err_q  <= 1'b0;
      byp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      func_po_q   <= func_po_d;
      upd_pulse_q <= upd_pulse_d;
      len_err_q   <= len_err_d;
      lock_err_q  <= lock_err_d;
      byp_q       <= byp_d;
    end
  end

  assign bus.func_po   = func_po_q;
  assign bus.upd_pulse = upd_pulse_q;
  assign bus.len_err   = len_err_q;
  assign bus.lock_err  = lock_err_q;
  assign bus.tdo       = ((state_q != IDLE) || sel_valid) ? chain[0] : byp_q;

endmodule

// File: tb/tb_hqm_aw_rtdr_bank.sv
// Self-checking bench for hqm_aw_rtdr_bank: directed scenarios plus random
// capture/shift/update transactions checked against a transaction-level model.
module tb_hqm_aw_rtdr_bank;

  localparam int          DW  = 8;
  localparam int          NR  = 4;
  localparam logic [7:0]  RST = 8'h5A;

  logic tck = 1'b0;
  logic trst;

  always #5 tck = ~tck;

  hqm_aw_rtdr_bank_if #(.DWIDTH(DW), .NUM_REG(NR)) bus ();

  hqm_aw_rtdr_bank #(
    .DWIDTH    (DW),
    .NUM_REG   (NR),
    .RESET_VAL (RST),
    .CHECK_LEN (1'b1)
  ) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_po [NR];
  bit         exp_len;
  bit         exp_lock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #2;
  endtask

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int r = 0; r < NR; r++) v[r*8 +: 8] = exp_po[r];
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] exp_pulse);
    check({tag, "_po"},    bus.func_po,   exp_vec());
    check({tag, "_pulse"}, bus.upd_pulse, exp_pulse);
    check({tag, "_len"},   bus.len_err,   exp_len);
    check({tag, "_lock"},  bus.lock_err,  exp_lock);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) exp_po[r] = RST;
    exp_len  = 1'b0;
    exp_lock = 1'b0;
  endtask

  task automatic capture_reg(input int r, input logic [7:0] pi);
    for (int s = 0; s < NR; s++) bus.func_pi[s] = 8'($urandom);
    bus.func_pi[r] = pi;
    bus.irdec      = 4'(1 << r);
    bus.capturedr  = 1'b1;
    step();
    bus.capturedr  = 1'b0;
  endtask

  // Word w = {tdi bits, captured value}: before shift k tdo shows w[k],
  // and after n shifts the chain holds w[n +: 8].
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      bus.shiftdr = 1'b1;
      bus.tdi     = w[8 + k];
      #1;
      check($sformatf("tdo_shift%0d", k), bus.tdo, w[k]);
      step();
    end
    bus.shiftdr = 1'b0;
  endtask

  task automatic run_txn(input int r, input logic [7:0] pi, input logic [23:0] tbits,
                         input int n, input bit unl, input bit clr);
    logic [31:0] w;
    bit          set_len, set_lock, do_commit;
    logic [3:0]  exp_pulse;
    w = {tbits, pi};
    capture_reg(r, pi);
    shift_bits(w, n);
    bus.updatedr = 1'b1;
    bus.unlock   = unl;
    bus.err_clr  = clr;
    step();
    bus.updatedr = 1'b0;
    bus.err_clr  = 1'b0;
    set_len   = (n != 8);
    set_lock  = !set_len && !unl;
    do_commit = !set_len && unl;
    exp_len   = set_len  || (exp_len  && !clr);
    exp_lock  = set_lock || (exp_lock && !clr);
    exp_pulse = 4'b0000;
    if (do_commit) begin
      exp_po[r] = w[n +: 8];
      exp_pulse = 4'(1 << r);
    end
    check_outputs("txn_upd", exp_pulse);
    step();
    check("txn_pulse_clear", bus.upd_pulse, 4'b0000);
  endtask

  task automatic clear_errors();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    exp_len  = 1'b0;
    exp_lock = 1'b0;
    check_outputs("err_clr", 4'b0000);
  endtask

  initial begin
    logic [31:0] w;
    trst          = 1'b1;
    bus.tdi       = 1'b0;
    bus.irdec     = '0;
    bus.capturedr = 1'b0;
    bus.shiftdr   = 1'b0;
    bus.updatedr  = 1'b0;
    bus.unlock    = 1'b1;
    bus.err_clr   = 1'b0;
    bus.func_pi   = '0;
    model_reset();
    step();
    step();
    trst = 1'b0;
    step();

    // Reset state
    check_outputs("reset", 4'b0000);
    check("reset_tdo", bus.tdo, 1'b0);

    // Full 8-shift update of register 1 with 0x3C over captured 0xA5
    run_txn(1, 8'hA5, 24'h00003C, 8, 1'b1, 1'b0);

    // Short shift: length error, then clear
    run_txn(1, 8'hA5, 24'h0000C3, 7, 1'b1, 1'b0);
    clear_errors();

    // Locked update, then unlocked commit leaves lock_err sticky
    run_txn(2, 8'h11, 24'h000099, 8, 1'b0, 1'b0);
    run_txn(2, 8'h22, 24'h0000E7, 8, 1'b1, 1'b0);
    check("lock_sticky", bus.lock_err, 1'b1);
    clear_errors();

    // Over-length shift and a set coinciding with err_clr
    run_txn(3, 8'h0F, 24'h0001F0, 9, 1'b1, 1'b1);

    // Bypass with multi-hot decode
    bus.irdec = 4'b0011;
    step();
    bus.shiftdr = 1'b1;
    bus.tdi     = 1'b1;
    step();
    check("byp_pre", bus.tdo, 1'b1);
    bus.shiftdr   = 1'b0;
    bus.capturedr = 1'b1;
    step();
    check("byp_cap", bus.tdo, 1'b0);
    bus.capturedr = 1'b0;
    bus.shiftdr   = 1'b1;
    bus.tdi       = 1'b1;
    step();
    check("byp_s1", bus.tdo, 1'b1);
    bus.tdi = 1'b0;
    step();
    check("byp_s0", bus.tdo, 1'b0);
    bus.shiftdr = 1'b0;
    check_outputs("byp", 4'b0000);

    // Decode moves away mid-shift: no commit, no error, chain held
    w = {24'h0000B4, 8'h96};
    capture_reg(1, 8'h96);
    shift_bits(w, 4);
    bus.irdec = 4'b0100;
    step();
    #1;
    check("abort_tdo", bus.tdo, w[4]);
    bus.updatedr = 1'b1;
    step();
    bus.updatedr = 1'b0;
    check_outputs("abort", 4'b0000);

    // Random transactions
    for (int t = 0; t < 60; t++) begin
      int   r, n;
      bit   unl, clr;
      r   = int'($urandom_range(0, NR - 1));
      n   = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(6, 10));
      unl = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 4) == 0);
      run_txn(r, 8'($urandom), 24'($urandom), n, unl, clr);
      if ($urandom_range(0, 7) == 0) clear_errors();
    end

    // Reset mid-shift after a committed value
    run_txn(1, 8'hA5, 24'h00003C, 8, 1'b1, 1'b0);
    run_txn(0, 8'h00, 24'h000001, 7, 1'b1, 1'b0);
    capture_reg(1, 8'h77);
    shift_bits({24'h000123, 8'h77}, 3);
    bus.shiftdr = 1'b1;
    trst        = 1'b1;
    step();
    trst        = 1'b0;
    bus.shiftdr = 1'b0;
    model_reset();
    check_outputs("trst", 4'b0000);
    bus.irdec    = 4'b0010;
    bus.updatedr = 1'b1;
    step();
    bus.updatedr = 1'b0;
    check_outputs("post_trst_upd", 4'b0000);
    step();
    check_outputs("post_trst_idle", 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
